// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter: accepts a WIDTH-bit word, emits it MSB- or
// LSB-first one bit per cycle, with seamless back-to-back words on the last bit.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             sl,
  input  logic             sr,
  output logic             ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             done,
  output logic             state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             msb_q, msb_d;
  logic             dout_q, dout_d;
  logic             last;
  logic             accept;

  // Handshake: a word is taken on a rising edge where load && ready; ready is
  // high in IDLE and during the cycle that carries the last bit of a word.
  assign last       = (state_q == SHIFT) && (cnt_q == CW'(WIDTH));
  assign ready      = (state_q == IDLE) || last;
  assign accept     = load && ready;
  assign dout       = dout_q;
  assign dout_valid = (state_q == SHIFT);
  assign done       = last;
  assign state_dbg  = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      msb_q   <= 1'b0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      msb_q   <= msb_d;
      dout_q  <= dout_d;
    end
  end

  // sh_q holds only the bits not yet emitted; cnt_q counts bits already on dout.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    msb_d   = msb_q;
    dout_d  = dout_q;
    if (accept) begin
      state_d = SHIFT;
      msb_d   = sl | ~sr;
      dout_d  = msb_d ? din[WIDTH-1] : din[0];
      sh_d    = msb_d ? (din << 1) : (din >> 1);
      cnt_d   = CW'(1);
    end else if (state_q == SHIFT) begin
      if (last) begin
        state_d = IDLE;
        sh_d    = '0;
        cnt_d   = '0;
        dout_d  = 1'b0;
      end else begin
        dout_d = msb_q ? sh_q[WIDTH-1] : sh_q[0];
        sh_d   = msb_q ? (sh_q << 1) : (sh_q >> 1);
        cnt_d  = cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: table of single words plus hand-written
// back-to-back, busy-rejection and mid-word reset sequences.
module tb_piso_serializer;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] din;
  logic       sl;
  logic       sr;
  logic       ready;
  logic       dout;
  logic       dout_valid;
  logic       done;
  logic       state_dbg;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] din;
    logic       sl;
    logic       sr;
    logic [7:0] seq;  // seq[7] is the first bit expected on dout
  } vec_t;

  vec_t vecs[5];

  piso_serializer #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .din        (din),
    .sl         (sl),
    .sr         (sr),
    .ready      (ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    check({name, ".ready"}, ready, 1'b1);
    check({name, ".dout"}, dout, 1'b0);
    check({name, ".valid"}, dout_valid, 1'b0);
    check({name, ".done"}, done, 1'b0);
  endtask

  // Accept one word, optionally scramble din/sl/sr while it is in flight.
  task automatic run_word(input vec_t v, input bit perturb);
    din  = v.din;
    sl   = v.sl;
    sr   = v.sr;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (perturb) begin
        din = 8'($urandom_range(0, 255));
        sl  = 1'($urandom_range(0, 1));
        sr  = 1'($urandom_range(0, 1));
      end
      check($sformatf("word%02h.bit%0d", v.din, i), dout, v.seq[7-i]);
      check($sformatf("word%02h.valid%0d", v.din, i), dout_valid, 1'b1);
      check($sformatf("word%02h.done%0d", v.din, i), done, (i == 7));
      check($sformatf("word%02h.ready%0d", v.din, i), ready, (i == 7));
      step();
    end
    check_idle($sformatf("word%02h.after", v.din));
  endtask

  // Word a MSB-first, then hold load with word b from cycle index hold_from;
  // b must only be taken on a's last-bit cycle.
  task automatic run_pair(input string name, input logic [7:0] a, input logic [7:0] b,
                          input int hold_from);
    logic [15:0] seq;
    logic        exp_q[$];
    logic        exp_bit;
    seq = {a, b};
    for (int i = 15; i >= 0; i--) exp_q.push_back(seq[i]);
    din  = a;
    sl   = 1'b1;
    sr   = 1'b0;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == hold_from) begin
        din  = b;
        load = 1'b1;
      end
      exp_bit = exp_q.pop_front();
      check($sformatf("%s.bit%0d", name, i), dout, exp_bit);
      check($sformatf("%s.valid%0d", name, i), dout_valid, 1'b1);
      check($sformatf("%s.done%0d", name, i), done, (i == 7 || i == 15));
      check($sformatf("%s.ready%0d", name, i), ready, (i == 7 || i == 15));
      step();
      if (i == 7) load = 1'b0;
    end
    check_idle({name, ".after"});
  endtask

  initial begin
    vecs[0] = '{din: 8'hA5, sl: 1'b1, sr: 1'b0, seq: 8'hA5};
    vecs[1] = '{din: 8'hA5, sl: 1'b0, sr: 1'b1, seq: 8'hA5};
    vecs[2] = '{din: 8'h01, sl: 1'b0, sr: 1'b1, seq: 8'h80};
    vecs[3] = '{din: 8'h3C, sl: 1'b0, sr: 1'b0, seq: 8'h3C};
    vecs[4] = '{din: 8'h01, sl: 1'b1, sr: 1'b1, seq: 8'h01};

    // reset with load held high: nothing may be accepted
    reset = 1'b0;
    load  = 1'b1;
    din   = 8'hFF;
    sl    = 1'b1;
    sr    = 1'b0;
    #1;
    check_idle("reset.async");
    step();
    step();
    check_idle("reset.held");
    load  = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_idle($sformatf("idle%0d", i));
    end

    for (int k = 0; k < 5; k++) run_word(vecs[k], (k >= 3));

    run_pair("b2b", 8'hF0, 8'h0F, 0);
    step();
    run_pair("busy", 8'h00, 8'hFF, 3);
    step();

    // reset mid-word at bit 4 of C3
    din  = 8'hC3;
    sl   = 1'b1;
    sr   = 1'b0;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("c3.bit%0d", i), dout, (i < 2));
      step();
    end
    check("c3.valid4", dout_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_idle("c3.abort");
    for (int i = 0; i < 2; i++) begin
      step();
      check_idle($sformatf("c3.held%0d", i));
    end
    reset = 1'b1;
    step();
    check_idle("c3.release");
    run_word('{din: 8'h3C, sl: 1'b1, sr: 1'b0, seq: 8'h3C}, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the parallel word width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port load  input  1  request to accept the word on din this cycle.
REQ-005 SHALL have port din  input  WIDTH  parallel word to serialize.
REQ-006 SHALL have port sl  input  1  shift-left mode select (MSB first); sampled only on accept.
REQ-007 SHALL have port sr  input  1  shift-right mode select (LSB first); sampled only on accept.
REQ-008 SHALL have port ready  output  1  block can accept a word this cycle.
REQ-009 SHALL have port dout  output  1  serial data bit, registered.
REQ-010 SHALL have port dout_valid  output  1  dout carries a payload bit this cycle.
REQ-011 SHALL have port done  output  1  one-cycle pulse coincident with the last bit of a word.

Function
REQ-012 SHALL implement FSM states IDLE and SHIFT, plus a shift register of WIDTH bits and a bit counter of clog2(WIDTH+1) bits.
REQ-013 SHALL accept a word on a rising edge where load=1 and ready=1; load while ready=0 SHALL be ignored with no state change.
REQ-014 SHALL drive ready=1 in IDLE, and in SHIFT only during the cycle carrying the last bit.
REQ-015 SHALL latch mode on accept: sl=1 -> MSB first (sl has priority over sr); sl=0,sr=1 -> LSB first; sl=0,sr=0 -> MSB first.
REQ-016 SHALL present the first bit on dout in the cycle immediately after the accepting edge (latency 1), and one subsequent bit per cycle for WIDTH consecutive cycles.
REQ-017 SHALL hold dout_valid=1 for exactly the WIDTH payload cycles of each word and 0 otherwise.
REQ-018 SHALL pulse done=1 for exactly one cycle, in the same cycle as the last payload bit.
REQ-019 SHALL, when a new word is accepted during the last-bit cycle, emit its first bit in the next cycle with no gap: dout_valid stays 1 and state stays SHIFT.
REQ-020 SHALL return to IDLE after the last bit when no new word is accepted, with dout=0 and dout_valid=0.
REQ-021 SHALL ignore changes on din, sl and sr outside the accepting edge; the word in flight is never altered.
REQ-022 SHALL fill vacated shift-register positions with 0.
REQ-023 SHALL never let the bit counter exceed WIDTH or wrap, and SHALL never re-emit a bit.

Reset
REQ-024 SHALL, on reset=0, asynchronously force state IDLE, shift register 0, counter 0, dout=0, dout_valid=0, done=0, ready=1.
REQ-025 SHALL, on reset asserted mid-word, abort the word immediately with no done pulse; after release, the partial word is never resumed.
REQ-026 SHALL ignore load while reset=0 and accept no word on the first edge where reset is still 0.

Verification
REQ-027 SHALL verify reset then idle: reset=0 for 2 cycles, then 1 with load=0 -> ready=1, dout=0, dout_valid=0, done=0 for 10 cycles.
REQ-028 SHALL verify MSB-first: din=8'hA5, sl=1, load for one cycle -> dout sequence 1,0,1,0,0,1,0,1 on the next 8 cycles; done on the 8th; then IDLE.
REQ-029 SHALL verify LSB-first: din=8'hA5, sl=0, sr=1 -> dout 1,0,1,0,0,1,0,1 in LSB order (bit0..bit7); and din=8'h01, sr=1 -> 1,0,0,0,0,0,0,0.
REQ-030 SHALL verify back-to-back: 8'hF0 then 8'h0F, both MSB first, with load held high -> 16 contiguous valid bits 11110000 00001111, two done pulses 8 cycles apart, and the second load accepted only in the last-bit cycle.
REQ-031 SHALL verify busy rejection: load=1 with din=8'hFF at bit 3 of 8'h00 -> the 8'h00 stream is unaffected, and 8'hFF is accepted only at the last-bit cycle.
REQ-032 SHALL verify reset mid-operation: reset=0 at bit 4 of 8'hC3 -> dout and dout_valid drop to 0 asynchronously with no done pulse; after release, ready=1 and a fresh 8'h3C serializes correctly.
